// File: rtl/ram_rd_arbiter_2to1.sv
// Round-robin 2:1 arbiter sharing one AXI4 read port; exactly one burst in flight.
// Latency: AR accepted in IDLE at cycle N -> m_axi_arvalid at N+1; R path is combinational.
// Backpressure: AR held stable until m_axi_arready; R valid/ready pass straight to/from the owner.
module ram_rd_arbiter_2to1 #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 6
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [1:0]                  s_axi_arvalid,
    output logic [1:0]                  s_axi_arready,
    input  logic [2*AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2*AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [15:0]                 s_axi_arlen,
    input  logic [5:0]                  s_axi_arsize,
    input  logic [3:0]                  s_axi_arburst,
    output logic [1:0]                  s_axi_rvalid,
    input  logic [1:0]                  s_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic [1:0]                  grant
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int IW = AXI_ID_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       prio_q;
    logic [1:0] grant_q;
    logic       win_idx;
    logic       ar_take;
    logic       own_idx;
    logic       r_fire;

    // A tie goes to prio; otherwise the single active requester wins.
    assign win_idx = (&s_axi_arvalid) ? prio_q : s_axi_arvalid[1];
    assign ar_take = aresetn && (state_q == IDLE) && (|s_axi_arvalid);
    assign own_idx = grant_q[1];
    assign r_fire  = (state_q == DATA) && m_axi_rvalid && s_axi_rready[own_idx];

    assign s_axi_arready = ar_take ? {win_idx, ~win_idx} : 2'b00;
    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_rready  = (state_q == DATA) && s_axi_rready[own_idx];
    assign s_axi_rvalid  = ((state_q == DATA) && m_axi_rvalid) ? {own_idx, ~own_idx} : 2'b00;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rid     = m_axi_rid;
    assign grant         = grant_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_take) state_d = ADDR;
            ADDR:    if (m_axi_arready) state_d = DATA;
            DATA:    if (r_fire && m_axi_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            grant_q       <= 2'b00;
            m_axi_araddr  <= '0;
            m_axi_arid    <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
        end else begin
            state_q <= state_d;
            if (ar_take) begin
                grant_q       <= {win_idx, ~win_idx};
                m_axi_araddr  <= win_idx ? s_axi_araddr[2*AW-1:AW] : s_axi_araddr[AW-1:0];
                m_axi_arid    <= win_idx ? s_axi_arid[2*IW-1:IW]   : s_axi_arid[IW-1:0];
                m_axi_arlen   <= win_idx ? s_axi_arlen[15:8]       : s_axi_arlen[7:0];
                m_axi_arsize  <= win_idx ? s_axi_arsize[5:3]       : s_axi_arsize[2:0];
                m_axi_arburst <= win_idx ? s_axi_arburst[3:2]      : s_axi_arburst[1:0];
            end
            // Priority only moves when a burst finishes, so contention alternates per burst.
            if (r_fire && m_axi_rlast) begin
                grant_q <= 2'b00;
                prio_q  <= ~own_idx;
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_arbiter_2to1.sv
// Bench for ram_rd_arbiter_2to1: random AR/R traffic against a round-robin reference model.
// Latency: n/a (testbench). Backpressure: drives random m_axi_arready stalls and s_axi_rready gaps.
// A simple RAM slave returns {addr, beat} data so lost or duplicated beats show up as data errors.
module tb_ram_rd_arbiter_2to1;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 6;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [1:0]        s_axi_arvalid, s_axi_arready;
    logic [2*AW-1:0]   s_axi_araddr;
    logic [2*IW-1:0]   s_axi_arid;
    logic [15:0]       s_axi_arlen;
    logic [5:0]        s_axi_arsize;
    logic [3:0]        s_axi_arburst;
    logic [1:0]        s_axi_rvalid, s_axi_rready;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic [IW-1:0]     s_axi_rid;
    logic [AW-1:0]     m_axi_araddr;
    logic [IW-1:0]     m_axi_arid;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]     m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic [IW-1:0]     m_axi_rid;
    logic              m_axi_rvalid, m_axi_rready;
    logic [1:0]        grant;

    always #5 aclk = ~aclk;

    ram_rd_arbiter_2to1 #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rid(m_axi_rid), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .grant(grant)
    );

    int total = 0;
    int bad   = 0;
    int model_prio;   // requester favoured on a tie: the one not served most recently

    logic [AW-1:0] addr_v  [2];
    logic [IW-1:0] id_v    [2];
    logic [7:0]    len_v   [2];
    logic [2:0]    size_v  [2];
    logic [1:0]    burst_v [2];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int exp_win(input logic [1:0] req);
        if (req == 2'b11) return model_prio;
        return req[1] ? 1 : 0;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < 2; i++) begin
            addr_v[i]  = $urandom;
            id_v[i]    = IW'($urandom);
            len_v[i]   = 8'($urandom_range(0, 6));
            size_v[i]  = 3'($urandom_range(0, 3));
            burst_v[i] = 2'($urandom_range(0, 2));
        end
    endtask

    // Plays requesters and RAM slave for one burst; reports observations, judges nothing itself.
    task automatic run_burst(input logic [1:0] req, input int ar_stall, input bit rr_rand,
                             input int abort_after, output int win, output bit lat_ok,
                             output int fbad, output int rbad, output int dbad,
                             output int nbeats, output bit tout);
        logic [AW-1:0] ea;
        logic [IW-1:0] eid;
        logic [7:0]    el;
        logic [2:0]    es;
        logic [1:0]    eb;
        logic [1:0]    oh;
        int            sbeat;
        bit            done;
        fbad = 0; rbad = 0; dbad = 0; nbeats = 0; tout = 0; lat_ok = 0; sbeat = 0; done = 0;
        s_axi_araddr  = {addr_v[1], addr_v[0]};
        s_axi_arid    = {id_v[1], id_v[0]};
        s_axi_arlen   = {len_v[1], len_v[0]};
        s_axi_arsize  = {size_v[1], size_v[0]};
        s_axi_arburst = {burst_v[1], burst_v[0]};
        s_axi_arvalid = req;
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b0;
        #1;
        case (s_axi_arready)
            2'b01:   win = 0;
            2'b10:   win = 1;
            default: win = -1;
        endcase
        if (win < 0) begin
            tout = 1;
            s_axi_arvalid = 2'b00;
            return;
        end
        ea = addr_v[win]; eid = id_v[win]; el = len_v[win]; es = size_v[win]; eb = burst_v[win];
        oh = (win == 1) ? 2'b10 : 2'b01;
        tick();
        s_axi_arvalid[win] = 1'b0;   // the loser keeps requesting through the whole burst
        lat_ok = (m_axi_arvalid === 1'b1);
        for (int c = 0; c <= ar_stall; c++) begin
            m_axi_arready = (c == ar_stall);
            m_axi_rvalid  = 1'b1;
            s_axi_rready  = 2'b11;
            #1;
            if ({m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {ea, eid, el, es, eb}
                || m_axi_arvalid !== 1'b1) fbad++;
            if (m_axi_rready !== 1'b0 || s_axi_rvalid !== 2'b00 || s_axi_arready !== 2'b00 || grant !== oh) rbad++;
            tick();
        end
        m_axi_arready = 1'b0;
        for (int c = 0; c < 400 && !done && !(abort_after > 0 && nbeats >= abort_after); c++) begin
            m_axi_rvalid = ($urandom_range(0, 3) != 0);
            m_axi_rdata  = {ea, 32'(sbeat)};
            m_axi_rresp  = 2'(sbeat);
            m_axi_rlast  = (sbeat == int'(el));
            m_axi_rid    = eid;
            s_axi_rready = rr_rand ? 2'($urandom) : 2'b11;
            #1;
            if (m_axi_rready !== s_axi_rready[win] || s_axi_rvalid !== (m_axi_rvalid ? oh : 2'b00)
                || s_axi_arready !== 2'b00 || m_axi_arvalid !== 1'b0 || grant !== oh) rbad++;
            if (s_axi_rvalid[win] && s_axi_rready[win]) begin
                if (s_axi_rdata !== {ea, 32'(nbeats)} || s_axi_rresp !== 2'(nbeats) || s_axi_rid !== eid
                    || s_axi_rlast !== (nbeats == int'(el))) dbad++;
                nbeats++;
                done = (nbeats == int'(el) + 1);
            end
            if (m_axi_rvalid && m_axi_rready) sbeat++;
            tick();
        end
        tout = !done && !(abort_after > 0 && nbeats >= abort_after);
        s_axi_arvalid = 2'b00;
        m_axi_rvalid  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        s_axi_arvalid = 2'($urandom);
        s_axi_araddr  = {$urandom, $urandom};
        s_axi_arid    = 12'($urandom);
        s_axi_arlen   = 16'($urandom);
        s_axi_arsize  = 6'($urandom);
        s_axi_arburst = 4'($urandom);
        s_axi_rready  = 2'($urandom);
        m_axi_arready = 1'($urandom);
        m_axi_rvalid  = 1'($urandom);
        m_axi_rdata   = {$urandom, $urandom};
        m_axi_rresp   = 2'($urandom);
        m_axi_rlast   = 1'($urandom);
        m_axi_rid     = IW'($urandom);
        repeat (3) tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b want=0", m_axi_arvalid); end
        total++; if (s_axi_arready !== 2'b00) begin bad++; $display("FAIL reset_arready got=%b want=00", s_axi_arready); end
        total++; if ({m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== '0) begin
            bad++; $display("FAIL reset_ar_fields got=%h want=0", {m_axi_araddr, m_axi_arid, m_axi_arlen}); end
        total++; if (m_axi_rready !== 1'b0 || s_axi_rvalid !== 2'b00) begin
            bad++; $display("FAIL reset_r_path got rready=%b rvalid=%b want 0/00", m_axi_rready, s_axi_rvalid); end
        s_axi_arvalid = 2'b00;
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b0;
        aresetn       = 1'b1;
        model_prio    = 0;
        tick();
    endtask

    task automatic test_contention();
        int w, fb, rb, db, nb, ew;
        bit lo, to;
        for (int k = 0; k < 3; k++) begin
            rand_fields();
            len_v[0] = 8'd0;
            len_v[1] = 8'd0;
            ew = exp_win(2'b11);
            run_burst(2'b11, 0, 1'b0, 0, w, lo, fb, rb, db, nb, to);
            total++; if (w !== ew) begin bad++; $display("FAIL contention_win[%0d] got=%0d want=%0d", k, w, ew); end
            total++; if (nb !== 1 || to) begin bad++; $display("FAIL contention_beats[%0d] got=%0d want=1 timeout=%0d", k, nb, to); end
            total++; if (fb + rb + db !== 0) begin bad++; $display("FAIL contention_proto[%0d] got field=%0d route=%0d data=%0d want 0", k, fb, rb, db); end
            model_prio = 1 - ew;
        end
    endtask

    task automatic test_single();
        int w, fb, rb, db, nb;
        bit lo, to;
        rand_fields();
        addr_v[0] = 32'h8000_1000;
        len_v[0]  = 8'd3;
        run_burst(2'b01, 0, 1'b0, 0, w, lo, fb, rb, db, nb, to);
        total++; if (w !== 0) begin bad++; $display("FAIL single_win got=%0d want=0", w); end
        total++; if (lo !== 1'b1) begin bad++; $display("FAIL single_arvalid_latency got=%0d want=1", lo); end
        total++; if (nb !== 4 || to) begin bad++; $display("FAIL single_beats got=%0d want=4 timeout=%0d", nb, to); end
        total++; if (fb + rb + db !== 0) begin bad++; $display("FAIL single_proto got field=%0d route=%0d data=%0d want 0", fb, rb, db); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_idle_grant got=%b want=00", grant); end
        model_prio = 1;
    endtask

    task automatic test_backpressure();
        int w, fb, rb, db, nb, ew;
        bit lo, to;
        rand_fields();
        len_v[1] = 8'd7;
        ew = exp_win(2'b10);
        run_burst(2'b10, 5, 1'b1, 0, w, lo, fb, rb, db, nb, to);
        total++; if (w !== ew) begin bad++; $display("FAIL bp_win got=%0d want=%0d", w, ew); end
        total++; if (fb !== 0) begin bad++; $display("FAIL bp_ar_stable got=%0d bad cycles want=0", fb); end
        total++; if (nb !== 8 || to) begin bad++; $display("FAIL bp_beats got=%0d want=8 timeout=%0d", nb, to); end
        total++; if (rb + db !== 0) begin bad++; $display("FAIL bp_r_path got route=%0d data=%0d want 0", rb, db); end
        model_prio = 1 - ew;
    endtask

    task automatic test_reset_mid_data();
        int w, fb, rb, db, nb, ew;
        bit lo, to;
        rand_fields();
        len_v[1] = 8'd7;
        run_burst(2'b10, 1, 1'b0, 2, w, lo, fb, rb, db, nb, to);
        total++; if (w !== exp_win(2'b10) || nb !== 2 || to) begin
            bad++; $display("FAIL abort_setup got win=%0d beats=%0d timeout=%0d want 1/2/0", w, nb, to); end
        aresetn = 1'b0;
        tick();
        aresetn      = 1'b1;
        m_axi_rvalid = 1'b1;
        s_axi_rready = 2'b11;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL abort_grant got=%b want=00", grant); end
        total++; if (m_axi_rready !== 1'b0 || s_axi_rvalid !== 2'b00) begin
            bad++; $display("FAIL abort_r_stalled got rready=%b rvalid=%b want 0/00", m_axi_rready, s_axi_rvalid); end
        m_axi_rvalid = 1'b0;
        model_prio = 0;
        rand_fields();
        ew = exp_win(2'b11);
        run_burst(2'b11, 0, 1'b1, 0, w, lo, fb, rb, db, nb, to);
        total++; if (w !== ew) begin bad++; $display("FAIL abort_fresh_win got=%0d want=%0d", w, ew); end
        total++; if (nb !== int'(len_v[ew]) + 1 || to || fb + rb + db !== 0) begin
            bad++; $display("FAIL abort_fresh_burst got beats=%0d timeout=%0d errs=%0d want %0d/0/0", nb, to, fb + rb + db, int'(len_v[ew]) + 1); end
        model_prio = 1 - ew;
    endtask

    task automatic test_random();
        int w, fb, rb, db, nb, ew;
        bit lo, to;
        logic [1:0] req;
        for (int k = 0; k < 25; k++) begin
            rand_fields();
            req = 2'($urandom_range(1, 3));
            ew  = exp_win(req);
            run_burst(req, $urandom_range(0, 3), 1'($urandom), 0, w, lo, fb, rb, db, nb, to);
            total++; if (w !== ew) begin bad++; $display("FAIL rand_win[%0d] req=%b got=%0d want=%0d", k, req, w, ew); end
            total++; if (nb !== int'(len_v[ew]) + 1 || to) begin
                bad++; $display("FAIL rand_beats[%0d] got=%0d want=%0d timeout=%0d", k, nb, int'(len_v[ew]) + 1, to); end
            total++; if (!lo || fb + rb + db !== 0) begin
                bad++; $display("FAIL rand_proto[%0d] got lat=%0d field=%0d route=%0d data=%0d want 1/0/0/0", k, lo, fb, rb, db); end
            total++; if (grant !== 2'b00) begin bad++; $display("FAIL rand_idle_grant[%0d] got=%b want=00", k, grant); end
            model_prio = 1 - ew;
        end
    endtask

    initial begin
        s_axi_arvalid = 2'b00;
        s_axi_rready  = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_reset_mid_data();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
